// File: rtl/trace_pkg.sv
// Shared types for the processor trace buffer: FSM state encoding and the packed trace record.
// Every file that handles trace entries imports this package.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_TRIG  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_t;

  // The struct is 100 bits wide. It packs as {pc, instr, alu, flags}, with flags = {V, C, Z, N}.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] alu;
    logic [3:0]  flags;
  } trace_entry_t;

endpackage

// File: rtl/trace_ram.sv
// Trace storage: DEPTH x trace_entry_t with one synchronous write port and one asynchronous read port.
// The contents are never reset. The read data is valid as soon as the address settles.
module trace_ram
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         i_we,
  input  logic [AW-1:0] i_waddr,
  input  trace_entry_t i_wdata,
  input  logic [AW-1:0] i_raddr,
  output trace_entry_t o_rdata
);

  trace_entry_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/trace_buffer.sv
// Trigger-based trace capture. The ring keeps the newest DEPTH samples and freezes POST_TRIG samples after the trigger PC.
// After capture ends, the entries are read out oldest-first through a first-word-fall-through valid/ready port.
module trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arm,
  input  logic [31:0]   trig_pc,
  input  logic [31:0]   pc_in,
  input  logic [31:0]   instr_in,
  input  logic [31:0]   alu_in,
  input  logic [3:0]    flags_in,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [31:0]   rd_pc,
  output logic [31:0]   rd_instr,
  output logic [31:0]   rd_alu,
  output logic [3:0]    rd_flags,
  output logic [CW-1:0] count,
  output logic [1:0]    state_out
);

  trace_state_t  r_state;
  logic [31:0]   r_prev_pc;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_post;

  logic          w_sample;
  logic          w_capturing;
  logic          w_we;
  logic          w_full;
  logic          w_pop;
  logic [CW-1:0] w_post_nxt;
  trace_entry_t  w_wdata;
  trace_entry_t  w_rdata;

  // A sample is any cycle where the PC differs from the previous cycle, so a stalled PC is recorded only once.
  assign w_sample    = (pc_in != r_prev_pc);
  assign w_capturing = (r_state == ST_ARMED) || (r_state == ST_TRIG);
  assign w_we        = !rst && !arm && w_capturing && w_sample;
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_pop       = rd_valid && rd_ready;
  assign w_post_nxt  = r_post + 1'b1;

  assign w_wdata.pc    = pc_in;
  assign w_wdata.instr = instr_in;
  assign w_wdata.alu   = alu_in;
  assign w_wdata.flags = flags_in;

  trace_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_prev_pc <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_post    <= '0;
    end else begin
      r_prev_pc <= pc_in;
      if (arm) begin
        r_state  <= ST_ARMED;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_post   <= '0;
      end else begin
        case (r_state)
          ST_ARMED, ST_TRIG: begin
            if (w_sample) begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
              // When the ring is full, the oldest entry is dropped by advancing the head.
              if (w_full) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
              end else begin
                r_count <= r_count + 1'b1;
              end
              if (r_state == ST_ARMED) begin
                if (pc_in == trig_pc) begin
                  r_state <= ST_TRIG;
                  r_post  <= '0;
                end
              end else begin
                r_post <= w_post_nxt;
                if (w_post_nxt == CW'(POST_TRIG)) begin
                  r_state <= ST_DONE;
                end
              end
            end
          end
          ST_DONE: begin
            if (w_pop) begin
              r_rd_ptr <= r_rd_ptr + 1'b1;
              r_count  <= r_count - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign rd_valid  = (r_state == ST_DONE) && (r_count != '0);
  assign rd_pc     = w_rdata.pc;
  assign rd_instr  = w_rdata.instr;
  assign rd_alu    = w_rdata.alu;
  assign rd_flags  = w_rdata.flags;
  assign count     = r_count;
  assign state_out = r_state;

endmodule

// File: tb/tb_trace_buffer.sv
// Directed bench for trace_buffer (DEPTH=16, POST_TRIG=8) with hand-computed expected values.
module tb_trace_buffer;

  localparam int DEPTH = 16;
  localparam int POST  = 8;
  localparam logic [31:0] PARK = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        arm = 1'b0;
  logic [31:0] trig_pc = 32'h0;
  logic [31:0] pc_in = 32'h0;
  logic [31:0] instr_in = 32'h0;
  logic [31:0] alu_in = 32'h0;
  logic [3:0]  flags_in = 4'h0;
  logic        rd_ready = 1'b0;
  logic        rd_valid;
  logic [31:0] rd_pc, rd_instr, rd_alu;
  logic [3:0]  rd_flags;
  logic [4:0]  count;
  logic [1:0]  state_out;

  int n_tests = 0;
  int n_fail  = 0;

  trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(POST)) dut (
    .clk       (clk),
    .rst       (rst),
    .arm       (arm),
    .trig_pc   (trig_pc),
    .pc_in     (pc_in),
    .instr_in  (instr_in),
    .alu_in    (alu_in),
    .flags_in  (flags_in),
    .rd_ready  (rd_ready),
    .rd_valid  (rd_valid),
    .rd_pc     (rd_pc),
    .rd_instr  (rd_instr),
    .rd_alu    (rd_alu),
    .rd_flags  (rd_flags),
    .count     (count),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are checked 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // During the arm cycle, the PC is parked on a unique value so that the next real PC counts as a sample.
  task automatic do_arm();
    arm   = 1'b1;
    pc_in = PARK;
    tick();
    arm   = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic [3:0] fl);
    pc_in    = pc;
    instr_in = ~pc;
    alu_in   = pc + 32'd1;
    flags_in = fl;
    tick();
  endtask

  initial begin
    #2;
    // Reset state
    rst = 1'b1;
    pc_in = 32'h1234;
    tick();
    rst = 1'b0;
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);

    // While the FSM is IDLE, samples are ignored.
    push(32'h2000, 4'h0);
    chk("idle_count", 32'(count), 32'd0);

    // Basic capture: trigger at 0x08, followed by 8 post-trigger samples.
    trig_pc = 32'h08;
    do_arm();
    chk("arm_state", 32'(state_out), 32'd1);
    chk("arm_discard", 32'(count), 32'd0);
    push(32'h00, 4'h0);
    push(32'h04, 4'b0100);
    push(32'h08, 4'h0);
    chk("trig_state", 32'(state_out), 32'd2);
    chk("trig_count", 32'(count), 32'd3);
    for (int i = 0; i < 8; i++) push(32'h0C + 32'(i * 4), 4'h0);
    chk("done_state", 32'(state_out), 32'd3);
    chk("done_count", 32'(count), 32'd11);
    chk("done_valid", 32'(rd_valid), 32'd1);
    chk("head_pc", rd_pc, 32'h00);
    chk("head_instr", rd_instr, 32'hFFFF_FFFF);
    chk("head_alu", rd_alu, 32'h01);
    push(32'h2C, 4'h0);
    chk("done_nowrite", 32'(count), 32'd11);

    // Drain the buffer with rd_ready held high: exactly 11 pops in order.
    rd_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      chk("pop_valid", 32'(rd_valid), 32'd1);
      chk("pop_pc", rd_pc, 32'(i * 4));
      if (i == 1) chk("pop_flags", 32'(rd_flags), 32'b0100);
      tick();
    end
    chk("drain_valid", 32'(rd_valid), 32'd0);
    chk("drain_state", 32'(state_out), 32'd3);
    chk("drain_count", 32'(count), 32'd0);
    tick();
    chk("idle_pop_count", 32'(count), 32'd0);
    chk("idle_pop_state", 32'(state_out), 32'd3);
    rd_ready = 1'b0;

    // Ring wrap: 20 pre-trigger samples, a trigger at 0x50, and 8 post-trigger samples.
    trig_pc = 32'h50;
    do_arm();
    for (int i = 0; i < 20; i++) push(32'(i * 4), 4'h0);
    chk("wrap_pre_count", 32'(count), 32'd16);
    chk("wrap_pre_state", 32'(state_out), 32'd1);
    push(32'h50, 4'h0);
    for (int i = 0; i < 8; i++) push(32'h54 + 32'(i * 4), 4'h0);
    chk("wrap_state", 32'(state_out), 32'd3);
    chk("wrap_count", 32'(count), 32'd16);
    chk("wrap_head", rd_pc, 32'h34);
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("wrap_pop_pc", rd_pc, 32'h34 + 32'(i * 4));
      tick();
    end
    rd_ready = 1'b0;
    chk("wrap_drained", 32'(rd_valid), 32'd0);

    // A constant PC is recorded only once. A reset during TRIGGERED discards the capture.
    trig_pc = 32'h1000;
    do_arm();
    push(32'h50, 4'h0);
    push(32'h58, 4'h0);
    chk("hold_first", 32'(count), 32'd2);
    for (int i = 0; i < 9; i++) tick();
    chk("hold_count", 32'(count), 32'd2);
    chk("hold_state", 32'(state_out), 32'd1);
    push(32'h1000, 4'h0);
    push(32'h1004, 4'h0);
    push(32'h1008, 4'h0);
    push(32'h100C, 4'h0);
    chk("mid_state", 32'(state_out), 32'd2);
    chk("mid_count", 32'(count), 32'd6);
    rst = 1'b1;
    arm = 1'b1;
    pc_in = 32'h1010;
    tick();
    rst = 1'b0;
    arm = 1'b0;
    chk("midrst_state", 32'(state_out), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_valid", 32'(rd_valid), 32'd0);

    // Arm while in DONE with 5 entries left in the buffer.
    trig_pc = 32'h08;
    do_arm();
    for (int i = 0; i < 11; i++) push(32'(i * 4), 4'h0);
    chk("rearm_pre_state", 32'(state_out), 32'd3);
    rd_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    rd_ready = 1'b0;
    chk("rearm_pre_count", 32'(count), 32'd5);
    chk("rearm_pre_head", rd_pc, 32'h18);
    do_arm();
    chk("rearm_state", 32'(state_out), 32'd1);
    chk("rearm_count", 32'(count), 32'd0);
    chk("rearm_valid", 32'(rd_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
